muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for the RV32M instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the main ALU in EX. The decoder raises start for M-type instructions; the block stalls the pipeline while iterating, then presents the result for one cycle.
- Uses an iterative shift-add multiply and a restoring divide: one bit per cycle, XLEN iterations.

Parameters:
- XLEN, 32, operand/result width. Iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (multiplicand/dividend)
- op_b  input  XLEN  rs2 value (multiplier/divisor)
- flush  input  1  abort the in-flight op (branch/exception flush)
- busy  output  1  high in CALC, FIX, DONE
- stall  output  1  pipeline hold: start&&IDLE, or state in {CALC, FIX}
- done  output  1  one-cycle pulse, high exactly in DONE
- result  output  XLEN  final value; holds until the next accepted start

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; internal accumulators, counter and latched funct3 cleared. Reset takes priority over flush and start, including mid-operation.
- States: IDLE, CALC, FIX, DONE. Encoding is in the shared package.
- IDLE, start=1 and flush=0:
  - Latch funct3.
  - Latch |op_a| and |op_b| per signedness: MULH signs both; MULHSU signs a only; DIV/REM sign both; others unsigned.
  - Latch the result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Counter=XLEN-1. Next state CALC.
- Fast path, checked at start:
  - Divisor==0: quotient=all ones; remainder=op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): quotient=0x80000000; remainder=0.
  - Both load result directly and go IDLE->DONE. done is high in the cycle after the start edge (latency 1).
- CALC:
  - Multiply: 2*XLEN product register. Each cycle, if the multiplier LSB is set, add the multiplicand into the upper half, then shift right 1.
  - Divide: {rem,quo} shift left 1; trial subtract divisor from rem; if no borrow, keep the difference and set quo LSB.
  - Counter decrements; counter==0 in CALC -> FIX. Exactly XLEN cycles in CALC.
- FIX:
  - Apply two's-complement negation per the latched sign.
  - Select the output: MUL = low half; MULH* = high half; DIV* = quotient; REM* = remainder.
  - Register into result. Next state DONE.
- DONE: done=1, stall=0 so the pipeline captures result this cycle. Next state IDLE unconditionally.
- Normal latency: start edge -> done high 34 cycles later (32 CALC + FIX + DONE).
- start outside IDLE is ignored. A start in DONE is not accepted; the decoder re-presents it (pipeline back-to-back: the next start is seen in IDLE).
- flush in CALC/FIX/DONE -> IDLE next edge, no done pulse, result unchanged.
- flush with start in IDLE: start is ignored.
- stall deasserts combinationally the same cycle flush is high.
- Arithmetic: all internal adders are XLEN+1 bits for the borrow/carry. No width truncation before FIX.

Decomposition:
- Add to defines.v: F3_MUL..F3_REMU codes; MD_IDLE/MD_CALC/MD_FIX/MD_DONE 2-bit state encodings.
- One sub-module, muldiv_operand_prep. It is combinational and takes funct3, op_a and op_b. It produces the absolute values, the result-sign bits, div_by_zero and overflow flags. It is reused for the FIX negation select.

Test Plan:
- MUL 7 x -3 (op_b=0xFFFFFFFD): result=0xFFFFFFEB; done exactly 34 cycles after start; stall high for 33 cycles.
- MULH/MULHSU/MULHU with op_a=op_b=0x80000000: results 0x40000000, 0xC0000000, 0x40000000 respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.
- DIV x/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM of the same -> 0. Each has done in the cycle after start.
- flush at CALC cycle 10: IDLE next edge; no done pulse; result keeps its prior value. A following DIVU 100/7 -> 14 completes normally.
- rst pulsed mid-CALC: busy=done=result=0 next edge; start raised during CALC is ignored (done count stays 1 for the op).

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the RV32M sequencer: FSM states, funct3 op codes and
// small decode helpers used by both the operand prep and the top-level datapath.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_is_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic f3_is_mulh(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
  endfunction

  // Low half of the 2*XLEN register holds the MUL product or the quotient.
  function automatic logic f3_sel_low(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_DIV) || (f3 == F3_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_operand_prep.sv
// Combinational operand conditioning: magnitudes, result sign and the
// divide special cases (divide-by-zero, signed overflow) with their results.
module muldiv_operand_prep
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] abs_a_o,
  output logic [XLEN-1:0] abs_b_o,
  output logic            res_neg_o,
  output logic            div_by_zero_o,
  output logic            overflow_o,
  output logic [XLEN-1:0] fast_result_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic sign_a;
  logic sign_b;
  logic is_div;
  logic is_rem;

  assign sign_a = f3_signed_a(funct3_i) & op_a_i[XLEN-1];
  assign sign_b = f3_signed_b(funct3_i) & op_b_i[XLEN-1];
  assign is_div = f3_is_div(funct3_i);
  assign is_rem = f3_is_rem(funct3_i);

  assign abs_a_o = sign_a ? (~op_a_i + XLEN'(1)) : op_a_i;
  assign abs_b_o = sign_b ? (~op_b_i + XLEN'(1)) : op_b_i;

  // The remainder takes the dividend's sign; products and quotients take sa^sb.
  assign res_neg_o = is_rem ? sign_a : (sign_a ^ sign_b);

  assign div_by_zero_o = is_div && (op_b_i == '0);
  assign overflow_o    = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                         (op_a_i == MIN_NEG) && (op_b_i == '1);

  always_comb begin
    fast_result_o = '0;
    if (div_by_zero_o) begin
      fast_result_o = is_rem ? op_a_i : '1;
    end else if (overflow_o) begin
      fast_result_o = is_rem ? '0 : op_a_i;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, sign fix-up in FIX, single-cycle done pulse in DONE.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            res_neg;
  logic            div_by_zero;
  logic            overflow;
  logic [XLEN-1:0] fast_result;

  muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
    .funct3_i      (funct3),
    .op_a_i        (op_a),
    .op_b_i        (op_b),
    .abs_a_o       (abs_a),
    .abs_b_o       (abs_b),
    .res_neg_o     (res_neg),
    .div_by_zero_o (div_by_zero),
    .overflow_o    (overflow),
    .fast_result_o (fast_result)
  );

  // Multiply step: acc = {product_hi, multiplier}; opnd = multiplicand.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

  // Divide step: acc = {rem, quo}; opnd = divisor. MSB of diff is the borrow.
  logic [XLEN:0]     rem_ext;
  logic [XLEN:0]     div_diff;
  logic              borrow;
  logic [2*XLEN-1:0] div_next;
  assign rem_ext  = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = rem_ext - {1'b0, opnd_q};
  assign borrow   = div_diff[XLEN];
  assign div_next = {(borrow ? rem_ext[XLEN-1:0] : div_diff[XLEN-1:0]),
                     acc_q[XLEN-2:0], ~borrow};

  // Negating a MULH high half needs the carry out of the negated low half.
  logic [XLEN-1:0] fix_lo, fix_hi, fix_sel, fix_val;
  logic            fix_sel_low, fix_cin;
  assign fix_lo      = acc_q[XLEN-1:0];
  assign fix_hi      = acc_q[2*XLEN-1:XLEN];
  assign fix_sel_low = f3_sel_low(f3_q);
  assign fix_sel     = fix_sel_low ? fix_lo : fix_hi;
  assign fix_cin     = fix_sel_low || !f3_is_mulh(f3_q) || (fix_lo == '0);
  assign fix_val     = neg_q ? (~fix_sel + XLEN'(fix_cin)) : fix_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    unique case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          f3_d  = funct3;
          neg_d = res_neg;
          if (div_by_zero || overflow) begin
            result_d = fast_result;
            state_d  = MD_DONE;
          end else begin
            opnd_d  = f3_is_div(funct3) ? abs_b : abs_a;
            acc_d   = {{XLEN{1'b0}}, (f3_is_div(funct3) ? abs_a : abs_b)};
            cnt_d   = CW'(XLEN - 1);
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = f3_is_div(f3_q) ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = MD_FIX;
          end
        end
      end
      MD_FIX: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          result_d = fix_val;
          state_d  = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy   = (state_q != MD_IDLE);
  assign done   = (state_q == MD_DONE);
  assign stall  = !flush && (((state_q == MD_IDLE) && start) ||
                             (state_q == MD_CALC) || (state_q == MD_FIX));
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench: the driver queues arithmetic expectations, a negedge monitor
// checks every done pulse for value and latency.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, stall, done;
  logic [31:0] result;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned issue;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // Reference model: plain wide arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result=%h expected no done pulse", result);
      end else begin
        e = exp_q.pop_front();
        $display("op f3=%0d a=%h b=%h result=%h expected=%h", e.f3, e.a, e.b, result, e.res);
        chk("result", result, e.res);
        chk("latency", cyc - e.issue, e.lat);
      end
    end
  end

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit noise);
    exp_t e;
    int   stall_cnt;
    bit   got;
    bit   fast;
    @(negedge clk);
    fast    = is_fast(f3, a, b);
    funct3  = f3;
    op_a    = a;
    op_b    = b;
    start   = 1'b1;
    e.res   = ref_model(f3, a, b);
    e.f3    = f3;
    e.a     = a;
    e.b     = b;
    e.issue = cyc;
    e.lat   = fast ? 1 : 34;
    exp_q.push_back(e);
    #1 chk("stall_on_start", stall, 1'b1);
    @(negedge clk);
    stall_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (stall) stall_cnt++;
      start = noise && (i >= 2) && (i < 6);
      if (start) begin
        funct3 = 3'($urandom_range(0, 7));
        op_a   = $urandom;
        op_b   = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done within 60 cycles expected done for f3=%0d", f3);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      chk("stall_cycles", stall_cnt, fast ? 0 : 33);
      chk("stall_in_done", stall, 1'b0);
      last_res = e.res;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_result", result, 32'h0);
    chk("reset_stall", stall, 1'b0);
    rst = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0);
    chk("mul_7x-3", last_res, 32'hFFFFFFEB);
    do_op(3'd1, 32'h80000000, 32'h80000000, 1'b0);
    do_op(3'd2, 32'h80000000, 32'h80000000, 1'b0);
    do_op(3'd3, 32'h80000000, 32'h80000000, 1'b0);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0);
    do_op(3'd5, 32'hFFFFFFFF, 32'h10, 1'b0);
    do_op(3'd4, 32'h12345678, 32'h0, 1'b0);
    do_op(3'd6, 32'd5, 32'h0, 1'b0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    // Flush ten cycles into CALC: no done, result keeps its last value.
    @(negedge clk);
    funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 chk("stall_during_flush", stall, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_done", done, 1'b0);
    chk("flush_result", result, last_res);
    do_op(3'd5, 32'd100, 32'd7, 1'b0);
    chk("divu_100_7", last_res, 32'd14);

    // Start requests during CALC must be ignored.
    do_op(3'd4, 32'hFFFF0000, 32'd77, 1'b1);

    // Reset mid-CALC.
    @(negedge clk);
    funct3 = 3'd3; op_a = 32'hDEADBEEF; op_b = 32'h12345; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 32'h0);
    rst = 1'b0;

    for (int n = 0; n < 150; n++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
